// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry-lookahead slice is reused once per
// nibble (LSB first), with the slice carry chained through a register between cycles.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is formed directly from cin and the generate/propagate terms,
    // so no carry depends on a lower carry inside the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic       last;

    // Handshake flags decode the state register only: no input reaches them combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (idx == IW'(N - 1));

    // NOTE: every variable written in always_comb gets a default first; otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    cla4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = RUN;
            RUN:     if (last)                 state_next = DONE;
            DONE:    if (out_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: operand registers are reset along with the result so an aborted
    // operation leaves no stale operand visible to the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == IW'(i)) sum[4*i +: 4] <= nib_sum;
                    end
                    carry <= nib_cout;
                    if (last) begin
                        cout <= nib_cout;
                        idx  <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Nibble-serial wide adder that feeds the team's 4-bit carry-lookahead adder slice. It accepts a WIDTH-bit operand pair, presents one 4-bit nibble per cycle to a single internal 4-bit CLA instance (LSB nibble first), and chains the slice's carry-out through a carry register. It returns the full WIDTH-bit sum and final carry over a valid/ready handshake. The block trades latency for area: it needs one CLA slice instead of WIDTH/4.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibbles.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and cin valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum/cout valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the top nibble.

## Operation
- Reset is synchronous and active-high. When rst is sampled high: state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, operand regs=0. After reset, in_ready=1 and out_valid=0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b, carry reg←cin, index←0, and go to RUN.
  - sum/cout keep their last values.
- RUN:
  - The CLA slice receives a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry reg, where i is the index.
  - Each edge: sum[4i+3:4i]←slice sum, carry reg←slice carry, index←i+1.
  - On the edge that processes i=N-1: cout←slice carry and go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready, go to IDLE. The next op can be accepted on the following cycle. No same-cycle turnaround.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Result must be bit-exact with WIDTH-bit unsigned addition.
- a, b and cin are sampled only on the accept edge. Changes during RUN/DONE have no effect.
- rst asserted in RUN or DONE aborts the operation: the result is discarded, the block returns to IDLE, and outputs take their reset values on the next cycle.
- Exactly one CLA instance. The nibble mux and the sum write use the index register. There is no combinational path from in_valid to out_valid or from out_ready to in_ready.

## Timing
- Let edge 0 be the accept edge.
  - RUN occupies edges 1..N.
  - out_valid rises after edge N: first visible in cycle N+1 relative to the accept cycle, i.e. latency N+1 cycles (5 for WIDTH=16).
- Minimum period between accepts is N+2 cycles: accept, N RUN cycles, one DONE cycle with out_ready=1.
- out_valid stays high and sum/cout stay constant for as long as out_ready=0.
- in_ready and out_valid are pure functions of state (registered), never both high.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0. Expect sum=0x5555, cout=0. out_valid first high N+1=5 cycles after accept. in_ready low from the cycle after accept until the cycle after the out handshake.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, so a carry propagates through all 4 nibbles across cycles. Then a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1 in both cases.
- Backpressure: a=0x8000, b=0x8000. Hold out_ready=0 for 6 cycles in DONE → sum=0x0000, cout=1 stable and out_valid high throughout. Raise out_ready → in_ready=1 on the next cycle.
- Input isolation: during RUN, toggle in_valid and change a/b/cin to random values. Expect no second accept and the result equal to the originally accepted operands. Also check that back-to-back ops achieve exactly N+2-cycle spacing.
- Reset mid-operation: accept 0x00FF+0x0001, assert rst for one cycle at RUN index 2 → next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0. A following 0x0001+0x0001 must yield 0x0002, cout=0.
- Random regression: 1000 random a/b/cin at WIDTH=16, plus WIDTH=4 (N=1, latency 2) and WIDTH=32. Compare {cout,sum} against a+b+cin with random out_ready stalls.
